// File: rtl/encoder_pulse_gen_if.sv
// Control and observation bundle for the quadrature pulse generator.
// The master side requests bursts; the slave side emits A/B and position.
interface encoder_pulse_gen_if #(
    parameter int PER_W = 16,
    parameter int CNT_W = 16
);
    logic                    start;
    logic                    stop;
    logic                    en;
    logic                    dir;
    logic [PER_W-1:0]        quarter_period;
    logic [CNT_W-1:0]        burst_len;
    logic                    enc_a;
    logic                    enc_b;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        pulse_count;
    logic [8:0]              deg;
    logic signed [10:0]      rev;

    modport master (
        output start, stop, en, dir,
        output quarter_period, burst_len,
        input  enc_a, enc_b, busy, done,
        input  pulse_count, deg, rev
    );

    modport slave (
        input  start, stop, en, dir,
        input  quarter_period, burst_len,
        output enc_a, enc_b, busy, done,
        output pulse_count, deg, rev
    );
endinterface

// File: rtl/encoder_pulse_gen.sv
// Quadrature A/B burst generator emulating a wheel encoder, with its own
// reference degree/revolution position for comparison against a decoder.
module encoder_pulse_gen #(
    parameter int PER_W = 16,
    parameter int CNT_W = 16,
    parameter int PPR   = 360
) (
    input  logic               WF_CLK,
    input  logic               rst,
    encoder_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PER_W-1:0]   qcnt;
    logic [PER_W-1:0]   q_lat;
    logic [CNT_W-1:0]   n_lat;
    logic [CNT_W-1:0]   cnt;
    logic               dir_lat;
    logic [1:0]         ph;
    logic [1:0]         ph_nxt;
    logic [8:0]         deg;
    logic signed [10:0] rev;
    logic               accept;
    logic               step;
    logic               rise;
    logic               fin;
    logic               busy;
    logic               done;

    assign accept = (state == IDLE) && bus.start
                  && (bus.quarter_period != '0);

    assign step = (state == RUN) && bus.en && !bus.stop
                && (qcnt == q_lat - PER_W'(1));

    // Gray-code walk: exactly one of A/B toggles per step.
    always_comb begin
        ph_nxt = ph;
        unique case ({dir_lat, ph})
            3'b0_00: ph_nxt = 2'b10;
            3'b0_10: ph_nxt = 2'b11;
            3'b0_11: ph_nxt = 2'b01;
            3'b0_01: ph_nxt = 2'b00;
            3'b1_00: ph_nxt = 2'b01;
            3'b1_01: ph_nxt = 2'b11;
            3'b1_11: ph_nxt = 2'b10;
            3'b1_10: ph_nxt = 2'b00;
        endcase
    end

    assign rise = step && !ph[1] && ph_nxt[1];
    assign fin  = step && (ph_nxt == 2'b00)
                && (n_lat != '0) && (cnt == n_lat);

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            state == RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (fin) begin
                    state_nxt = DONE;
                end
            end
            state == DONE: state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            qcnt    <= '0;
            q_lat   <= '0;
            n_lat   <= '0;
            cnt     <= '0;
            dir_lat <= 1'b0;
            ph      <= 2'b00;
            deg     <= '0;
            rev     <= '0;
        end else begin
            if (accept) begin
                dir_lat <= bus.dir;
                q_lat   <= bus.quarter_period;
                n_lat   <= bus.burst_len;
                cnt     <= '0;
                qcnt    <= '0;
                ph      <= 2'b00;
            end else if (state == RUN) begin
                if (bus.stop) begin
                    ph   <= 2'b00;
                    qcnt <= '0;
                end else if (bus.en) begin
                    if (step) begin
                        qcnt <= '0;
                        ph   <= ph_nxt;
                    end else begin
                        qcnt <= qcnt + PER_W'(1);
                    end
                end
            end
            // Position follows the rising edge of A in either direction.
            if (rise) begin
                cnt <= cnt + CNT_W'(1);
                if (!dir_lat) begin
                    if (deg == 9'(PPR - 1)) begin
                        deg <= '0;
                        rev <= rev + 11'sd1;
                    end else begin
                        deg <= deg + 9'd1;
                    end
                end else begin
                    if (deg == '0) begin
                        deg <= 9'(PPR - 1);
                        rev <= rev - 11'sd1;
                    end else begin
                        deg <= deg - 9'd1;
                    end
                end
            end
        end
    end

    assign bus.enc_a       = ph[1];
    assign bus.enc_b       = ph[0];
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pulse_count = cnt;
    assign bus.deg         = deg;
    assign bus.rev         = rev;
endmodule

// File: tb/tb_encoder_pulse_gen.sv
// Bench for encoder_pulse_gen: directed scenarios plus a randomized run,
// all compared against an elapsed-time/position reference model.
module tb_encoder_pulse_gen;
    localparam int PPR = 360;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    encoder_pulse_gen_if bus ();

    encoder_pulse_gen #(
        .PER_W(16),
        .CNT_W(16),
        .PPR  (PPR)
    ) dut (
        .WF_CLK(clk),
        .rst   (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed enabled cycles and signed pulse position.
    bit         m_run;
    bit         m_done;
    bit         m_dir;
    int         m_q;
    int         m_n;
    int         m_e;
    int         m_cnt;
    int         m_pos;
    logic [1:0] m_ab;

    function automatic logic [1:0] seq_ab(bit d, int s);
        case (s % 4)
            0:       return 2'b00;
            1:       return d ? 2'b01 : 2'b10;
            2:       return 2'b11;
            default: return d ? 2'b10 : 2'b01;
        endcase
    endfunction

    task automatic model_edge();
        int s;
        logic [1:0] prev;
        if (rst) begin
            m_run = 0; m_done = 0; m_e = 0;
            m_cnt = 0; m_pos = 0; m_ab = 2'b00;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (bus.start && bus.quarter_period != 0) begin
                m_run = 1;
                m_dir = bus.dir;
                m_q   = int'(bus.quarter_period);
                m_n   = int'(bus.burst_len);
                m_e   = 0;
                m_cnt = 0;
            end
        end else if (bus.stop) begin
            m_run = 0;
            m_ab  = 2'b00;
        end else if (bus.en) begin
            m_e++;
            if (m_e % m_q == 0) begin
                s    = m_e / m_q;
                prev = seq_ab(m_dir, s - 1);
                m_ab = seq_ab(m_dir, s);
                if (m_ab[1] && !prev[1]) begin
                    m_cnt++;
                    m_pos += m_dir ? -1 : 1;
                end
                if (m_n != 0 && s == 4 * m_n) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    function automatic logic [39:0] exp_vec();
        int d;
        int r;
        d = m_pos % PPR;
        if (d < 0) d += PPR;
        r = (m_pos - d) / PPR;
        return {m_ab, m_run, m_done, 16'(m_cnt), 9'(d), 11'(r)};
    endfunction

    function automatic logic [39:0] act_vec();
        return {bus.enc_a, bus.enc_b, bus.busy, bus.done,
                bus.pulse_count, bus.deg, bus.rev};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic kick(bit d, int q, int n);
        bus.dir            = d;
        bus.quarter_period = 16'(q);
        bus.burst_len      = 16'(n);
        bus.start          = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        bus.start          = 1'b1;
        bus.quarter_period = 16'd3;
        tick();
        bus.start = 1'b0;
        total++;
        if (act_vec() !== 40'h0) begin
            bad++;
            $display("FAIL reset got=%h exp=0", act_vec());
        end
        rst = 1'b0;
        tick();
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_forward();
        int ra[$];
        int rb[$];
        int done_at = -1;
        logic pa = 1'b0;
        logic pb = 1'b0;
        kick(1'b0, 3, 4);
        for (int c = 1; c <= 60; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fwd_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (bus.enc_a && !pa) ra.push_back(c);
            if (bus.enc_b && !pb) rb.push_back(c);
            if (bus.done && done_at < 0) done_at = c;
            pa = bus.enc_a;
            pb = bus.enc_b;
        end
        if (ra.size() < 2) ra = '{-1, -1};
        if (rb.size() < 1) rb = '{-1};
        total++;
        if (ra[0] !== 3) begin
            bad++;
            $display("FAIL fwd_a_rise got=%0d exp=3", ra[0]);
        end
        total++;
        if (ra[1] - ra[0] !== 12) begin
            bad++;
            $display("FAIL fwd_period got=%0d exp=12", ra[1] - ra[0]);
        end
        total++;
        if (rb[0] - ra[0] !== 3) begin
            bad++;
            $display("FAIL fwd_b_lag got=%0d exp=3", rb[0] - ra[0]);
        end
        total++;
        if (done_at !== 48) begin
            bad++;
            $display("FAIL fwd_done_at got=%0d exp=48", done_at);
        end
        total++;
        if ({bus.pulse_count, bus.deg, bus.rev} !== {16'd4, 9'd4, 11'd0}) begin
            bad++;
            $display("FAIL fwd_final cnt=%0d deg=%0d rev=%0d exp 4/4/0",
                     bus.pulse_count, bus.deg, bus.rev);
        end
    endtask

    task automatic test_reverse();
        int ra[$];
        int rb[$];
        int dg[$];
        int done_at = -1;
        logic pa = 1'b0;
        logic pb = 1'b0;
        do_reset();
        kick(1'b1, 2, 2);
        for (int c = 1; c <= 30; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rev_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (bus.enc_a && !pa) begin
                ra.push_back(c);
                dg.push_back(int'(bus.deg));
            end
            if (bus.enc_b && !pb) rb.push_back(c);
            if (bus.done && done_at < 0) done_at = c;
            pa = bus.enc_a;
            pb = bus.enc_b;
        end
        if (ra.size() < 1) ra = '{-1};
        if (rb.size() < 1) rb = '{-1};
        if (dg.size() < 2) dg = '{-1, -1};
        total++;
        if (rb[0] !== 2 || ra[0] - rb[0] !== 2) begin
            bad++;
            $display("FAIL rev_b_lead b=%0d a=%0d exp b=2 a=4", rb[0], ra[0]);
        end
        total++;
        if (dg[0] !== 359 || dg[1] !== 358) begin
            bad++;
            $display("FAIL rev_deg got=%0d,%0d exp=359,358", dg[0], dg[1]);
        end
        total++;
        if (bus.rev !== -11'sd1) begin
            bad++;
            $display("FAIL rev_rev got=%0d exp=-1", bus.rev);
        end
        total++;
        if (done_at !== 16) begin
            bad++;
            $display("FAIL rev_done_at got=%0d exp=16", done_at);
        end
    endtask

    task automatic test_wrap();
        int done_at = -1;
        int pdeg = 0;
        int prev = 0;
        logic [8:0] ddeg = '0;
        logic signed [10:0] drev = '0;
        do_reset();
        kick(1'b0, 1, 361);
        for (int c = 1; c <= 1500; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (int'(bus.rev) != prev) begin
                total++;
                if (!(pdeg == 359 && bus.deg == 0)) begin
                    bad++;
                    $display("FAIL wrap_rev_step c=%0d deg %0d->%0d exp 359->0",
                             c, pdeg, bus.deg);
                end
            end
            if (bus.done && done_at < 0) begin
                done_at = c;
                ddeg = bus.deg;
                drev = bus.rev;
            end
            pdeg = int'(bus.deg);
            prev = int'(bus.rev);
        end
        total++;
        if (done_at !== 1444 || ddeg !== 9'd1 || drev !== 11'sd1) begin
            bad++;
            $display("FAIL wrap_done at=%0d deg=%0d rev=%0d exp 1444/1/1",
                     done_at, ddeg, drev);
        end
    endtask

    task automatic test_enable();
        int done_at = -1;
        logic [39:0] snap = '0;
        do_reset();
        kick(1'b0, 3, 4);
        for (int c = 1; c <= 70; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL en_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (c > 5 && c <= 15) begin
                total++;
                if (act_vec() !== snap) begin
                    bad++;
                    $display("FAIL en_freeze c=%0d got=%h exp=%h",
                             c, act_vec(), snap);
                end
            end
            if (c == 5) begin
                bus.en = 1'b0;
                snap = act_vec();
            end
            if (c == 15) bus.en = 1'b1;
            if (bus.done && done_at < 0) done_at = c;
        end
        total++;
        if (done_at !== 58) begin
            bad++;
            $display("FAIL en_done_at got=%0d exp=58", done_at);
        end
    endtask

    task automatic test_stop();
        bit saw_done = 0;
        int done_at = -1;
        do_reset();
        kick(1'b0, 2, 5);
        for (int c = 1; c <= 40; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL stop_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (bus.done) saw_done = 1;
            if (c == 13) begin
                bus.stop = 1'b0;
                total++;
                if ({bus.enc_a, bus.enc_b, bus.busy, bus.pulse_count}
                    !== {3'b000, 16'd2}) begin
                    bad++;
                    $display("FAIL stop_state a=%b b=%b busy=%b cnt=%0d exp 0/0/0/2",
                             bus.enc_a, bus.enc_b, bus.busy, bus.pulse_count);
                end
            end
            if (c == 12) bus.stop = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL stop_no_done got=%0d exp=0", saw_done);
        end
        kick(1'b0, 2, 5);
        total++;
        if (bus.busy !== 1'b1 || bus.pulse_count !== 16'd0) begin
            bad++;
            $display("FAIL stop_restart busy=%b cnt=%0d exp 1/0",
                     bus.busy, bus.pulse_count);
        end
        for (int c = 1; c <= 45; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL stop_rerun c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (bus.done && done_at < 0) done_at = c;
        end
        total++;
        if (done_at !== 40 || bus.pulse_count !== 16'd5 || bus.deg !== 9'd7) begin
            bad++;
            $display("FAIL stop_rerun_end at=%0d cnt=%0d deg=%0d exp 40/5/7",
                     done_at, bus.pulse_count, bus.deg);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.dir            = 1'b0;
        bus.quarter_period = 16'd1;
        bus.burst_len      = 16'd1;
        bus.start          = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (c == 5) begin
                total++;
                if (bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle busy=%b exp=0", bus.busy);
                end
            end
            if (c == 6) begin
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_restart busy=%b exp=1", bus.busy);
                end
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_zero_q();
        do_reset();
        bus.quarter_period = 16'd0;
        bus.burst_len      = 16'd2;
        bus.start          = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (bus.busy !== 1'b0 || act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL zero_q c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_rst_mid();
        kick(1'b1, 2, 3);
        for (int c = 1; c <= 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (act_vec() !== 40'h0) begin
            bad++;
            $display("FAIL rst_mid got=%h exp=0", act_vec());
        end
    endtask

    task automatic test_random();
        int ndone = 0;
        for (int c = 0; c < 3000; c++) begin
            rst                = ($urandom % 500) == 0;
            bus.start          = ($urandom % 6) == 0;
            bus.stop           = ($urandom % 50) == 0;
            bus.en             = ($urandom % 4) != 0;
            bus.dir            = 1'($urandom % 2);
            bus.quarter_period = 16'($urandom % 4);
            bus.burst_len      = 16'($urandom % 4);
            tick();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rand_cycle c=%0d got=%h exp=%h",
                         c, act_vec(), exp_vec());
            end
            if (bus.done) ndone++;
        end
        total++;
        if (ndone == 0) begin
            bad++;
            $display("FAIL rand_no_done got=0 exp>0");
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.en    = 1'b1;
    endtask

    initial begin
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.stop           = 1'b0;
        bus.en             = 1'b1;
        bus.dir            = 1'b0;
        bus.quarter_period = 16'd0;
        bus.burst_len      = 16'd0;
        m_run = 0; m_done = 0; m_dir = 0;
        m_q = 1; m_n = 0; m_e = 0; m_cnt = 0; m_pos = 0;
        m_ab = 2'b00;
        test_reset();
        test_forward();
        test_reverse();
        test_wrap();
        test_enable();
        test_stop();
        test_back_to_back();
        test_zero_q();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
